// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and helpers for the 7-segment scan controller.
//   state_e     : scan FSM states (IDLE, DRIVE, GAP)
//   BCD_INVALID : nibble sent to the decoder for a non-BCD digit
//   is_bcd()    : true when a nibble is a valid decimal digit (0..9)
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= 4'd9);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Control and display bus of the scan controller.
//   en, load, bcd_in                   : driven by the master (host side)
//   bcd_out, an, digit_idx, frame_done : driven by the slave (scan controller)
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic                          en;
    logic                          load;
    logic [4*NUM_DIGITS-1:0]       bcd_in;
    logic [3:0]                    bcd_out;
    logic [NUM_DIGITS-1:0]         an;
    logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
    logic                          frame_done;

    modport master (
        output en, load, bcd_in,
        input  bcd_out, an, digit_idx, frame_done
    );

    modport slave (
        input  en, load, bcd_in,
        output bcd_out, an, digit_idx, frame_done
    );

endinterface

// File: rtl/seg7_prescaler.sv
// -----------------------------------------------------------------------------
// seg7_prescaler
// Scan tick generator: counts 0..CLK_DIV-1, tick is high in the last count.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : hold the counter at 0
//   tick : high while the count equals CLK_DIV-1
// -----------------------------------------------------------------------------
module seg7_prescaler #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] pcnt_r;
    logic             tick_s;

    assign tick_s = (pcnt_r == CNT_W'(CLK_DIV - 1));
    assign tick   = tick_s;

    // Prescaler counter with wrap at the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= {CNT_W{1'b0}};
        end else if (clr || tick_s) begin
            pcnt_r <= {CNT_W{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for an N-digit common-anode display sharing
// one external BCD-to-7-segment decoder. Each digit gets a DRIVE phase followed
// by a blanking GAP phase, each CLK_DIV cycles long. A shadow (pending) register
// is copied into the displayed (active) value only at frame boundaries.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seg7_scan_ctrl_if.slave (en, load, bcd_in -> bcd_out, an,
//              digit_idx, frame_done), all outputs registered
// Optional feature macro: SEG7_LZB_EN (leading-zero blanking).
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_ctrl_if.slave        bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    state_e                  state_r, state_nxt_s;
    logic [IDX_W-1:0]        digit_r, digit_nxt_s;
    logic [DW-1:0]           pending_r, pending_nxt_s;
    logic [DW-1:0]           active_r, active_nxt_s;
    logic                    pend_vld_r, pend_vld_nxt_s;
    logic [NUM_DIGITS-1:0]   an_r, an_nxt_s;
    logic [3:0]              bcd_out_r, bcd_nxt_s;
    logic                    frame_done_r;
    logic                    copy_pt_s, swap_s, copy_s, tick_s, clr_s;
    logic [3:0]              nib_s;
    logic                    lzb_blank_s;

    assign clr_s = (state_r == IDLE) || !bus.en;

    seg7_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Next-state logic: phase sequencing, digit advance and frame swap points.
    always_comb begin
        state_nxt_s = state_r;
        digit_nxt_s = digit_r;
        copy_pt_s   = 1'b0;
        swap_s      = 1'b0;
        if (!bus.en) begin
            state_nxt_s = IDLE;
            digit_nxt_s = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = DRIVE;
                    digit_nxt_s = {IDX_W{1'b0}};
                    copy_pt_s   = 1'b1;
                end
                DRIVE: begin
                    if (tick_s) begin
                        state_nxt_s = GAP;
                    end else begin
                        state_nxt_s = DRIVE;
                    end
                end
                GAP: begin
                    if (tick_s) begin
                        state_nxt_s = DRIVE;
                        if (digit_r == IDX_W'(NUM_DIGITS - 1)) begin
                            digit_nxt_s = {IDX_W{1'b0}};
                            swap_s      = 1'b1;
                            copy_pt_s   = 1'b1;
                        end else begin
                            digit_nxt_s = digit_r + IDX_W'(1);
                        end
                    end else begin
                        state_nxt_s = GAP;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    digit_nxt_s = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Shadow register handling; a load coinciding with a copy bypasses pending.
    always_comb begin
        copy_s         = copy_pt_s && pend_vld_r;
        active_nxt_s   = active_r;
        pending_nxt_s  = pending_r;
        pend_vld_nxt_s = pend_vld_r;
        if (copy_s) begin
            active_nxt_s   = bus.load ? bus.bcd_in : pending_r;
            pend_vld_nxt_s = 1'b0;
        end else if (bus.load) begin
            pending_nxt_s  = bus.bcd_in;
            pend_vld_nxt_s = 1'b1;
        end else begin
            pend_vld_nxt_s = pend_vld_r;
        end
    end

    // Output decode from the next state so registered outputs align with it.
    always_comb begin
        nib_s       = active_nxt_s[4*digit_nxt_s +: 4];
        lzb_blank_s = 1'b0;
`ifdef SEG7_LZB_EN
        // Blank digit k>0 when it and every more significant digit are zero.
        lzb_blank_s = (digit_nxt_s != {IDX_W{1'b0}});
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(digit_nxt_s)) && (active_nxt_s[4*j +: 4] != 4'd0)) begin
                lzb_blank_s = 1'b0;
            end else begin
                lzb_blank_s = lzb_blank_s;
            end
        end
`endif
        an_nxt_s  = {NUM_DIGITS{1'b1}};
        bcd_nxt_s = bcd_out_r;
        if (state_nxt_s == DRIVE) begin
            if (!is_bcd(nib_s)) begin
                bcd_nxt_s = BCD_INVALID;
            end else if (lzb_blank_s) begin
                bcd_nxt_s = 4'd0;
            end else begin
                bcd_nxt_s = nib_s;
                an_nxt_s  = ~(NUM_DIGITS'(1) << digit_nxt_s);
            end
        end else begin
            bcd_nxt_s = bcd_out_r;
        end
    end

    // State, data and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            digit_r      <= {IDX_W{1'b0}};
            pending_r    <= {DW{1'b0}};
            active_r     <= {DW{1'b0}};
            pend_vld_r   <= 1'b0;
            an_r         <= {NUM_DIGITS{1'b1}};
            bcd_out_r    <= 4'd0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            digit_r      <= digit_nxt_s;
            pending_r    <= pending_nxt_s;
            active_r     <= active_nxt_s;
            pend_vld_r   <= pend_vld_nxt_s;
            an_r         <= an_nxt_s;
            bcd_out_r    <= bcd_nxt_s;
            frame_done_r <= swap_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.bcd_out    = bcd_out_r;
    assign bus.digit_idx  = digit_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Bench for seg7_scan_ctrl with NUM_DIGITS=4, CLK_DIV=2. A reference model
// derives the expected display from elapsed scan time and queues one expected
// output set per clock; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int D = 2;
    localparam int F = 2 * N * D;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] idx;
        logic       fd;
        logic       pv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: display content is a function of cycles since enable.
    initial begin : model
        bit          run;
        int          t, phase, digit, nib;
        logic [15:0] pend, act;
        bit          pv, copy_pt, swap;
        logic [3:0]  bcd;
        exp_t        e;
        run = 0; t = 0; pend = 16'h0; act = 16'h0; pv = 0; bcd = 4'h0;
        forever begin
            @(posedge clk);
            if (rst) begin
                run = 0; t = 0; pend = 16'h0; act = 16'h0; pv = 0; bcd = 4'h0;
                e = '{an: 4'hF, bcd: 4'h0, idx: 2'd0, fd: 1'b0, pv: 1'b0};
            end else begin
                copy_pt = 0;
                swap    = 0;
                if (bus.en) begin
                    if (!run) begin
                        t = 0;
                        copy_pt = 1;
                    end else begin
                        t++;
                        if (t % F == 0) begin
                            swap = 1;
                            copy_pt = 1;
                        end
                    end
                end
                if (copy_pt && pv) begin
                    act = bus.load ? bus.bcd_in : pend;
                    pv  = 0;
                end else if (bus.load) begin
                    pend = bus.bcd_in;
                    pv   = 1;
                end
                e.an  = 4'hF;
                e.idx = 2'd0;
                e.fd  = swap;
                e.pv  = pv;
                if (!bus.en) begin
                    run = 0;
                end else begin
                    run   = 1;
                    phase = t / D;
                    digit = (phase / 2) % N;
                    e.idx = 2'(digit);
                    if (phase % 2 == 0) begin
                        nib = int'((act >> (4 * digit)) & 16'hF);
                        if (nib > 9) begin
                            bcd = 4'hF;
                        end else if (LZB && digit > 0 && (act >> (4 * digit)) == 16'h0) begin
                            bcd = 4'h0;
                        end else begin
                            bcd  = 4'(nib);
                            e.an = ~(4'b0001 << digit);
                        end
                    end
                end
                e.bcd = bcd;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the DUT outputs against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("an",         8'(bus.an),         8'(e.an));
                chk("bcd_out",    8'(bus.bcd_out),    8'(e.bcd));
                chk("digit_idx",  8'(bus.digit_idx),  8'(e.idx));
                chk("frame_done", 8'(bus.frame_done), 8'(e.fd));
                chk("pend_vld",   8'(dut.pend_vld_r), 8'(e.pv));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic wait_for(input logic [1:0] idx, input logic [3:0] an, input string name);
        bit hit;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (bus.digit_idx == idx && bus.an == an) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_%s actual=timeout required=idx %0d an %b", name, idx, an);
        end
    endtask

    initial begin : stimulus
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        do_load(16'h1234);
        bus.en = 1'b1;
        cyc(40);

        wait_for(2'd2, 4'b1011, "digit2_drive");
        do_load(16'h5678);
        cyc(40);

        do_load(16'h12A4);
        cyc(40);

        wait_for(2'd2, 4'b1111, "digit2_gap");
        bus.en = 1'b0;
        cyc(3);
        bus.en = 1'b1;
        cyc(20);

        do_load(16'h0042);
        cyc(40);

        for (int i = 0; i < 400; i++) begin
            bus.load   = ($urandom_range(0, 7) == 0);
            bus.bcd_in = 16'($urandom);
            if ($urandom_range(0, 29) == 0) bus.en = ~bus.en;
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        bus.load = 1'b0;
        rst      = 1'b0;
        bus.en   = 1'b1;
        cyc(5);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
